// File: rtl/cv32e40p_pkg.sv
// Shared types and helpers for the fault-tolerant multiplier monitor.
package cv32e40p_pkg;

  localparam int unsigned FT_NREP = 3;

  typedef enum logic [1:0] {
    FT_OK       = 2'd0,
    FT_DEGRADED = 2'd1,
    FT_FAILED   = 2'd2
  } ft_mon_state_e;

  function automatic logic [1:0] popcount3(input logic [2:0] v);
    return 2'(v[0]) + 2'(v[1]) + 2'(v[2]);
  endfunction

endpackage

// File: rtl/cv32e40p_ft_err_counter.sv
// Per-replica error counter: saturating increment, leak decrement, frozen once isolated.
module cv32e40p_ft_err_counter #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_i,
  input  logic             leak_i,
  input  logic             freeze_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] r_cnt;
  logic             w_dec;

  // A leak only takes effect on a nonzero count; it then cancels a same-cycle increment.
  assign w_dec = leak_i && (r_cnt != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (!freeze_i) begin
      if (inc_i && !w_dec) begin
        if (r_cnt != '1) r_cnt <= r_cnt + CNT_W'(1);
      end else if (w_dec && !inc_i) begin
        r_cnt <= r_cnt - CNT_W'(1);
      end
    end
  end

  assign cnt_o = r_cnt;

endmodule

// File: rtl/cv32e40p_mult_ft_monitor.sv
// Health monitor for the TMR multiplier: per-replica leaky error counters,
// replica isolation and an OK/DEGRADED/FAILED state machine.
module cv32e40p_mult_ft_monitor
  import cv32e40p_pkg::*;
#(
  parameter int unsigned THRESH = 4,
  parameter int unsigned CNT_W  = 8,
  parameter int unsigned WINDOW = 256
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 valid_i,
  input  logic [2:0]           err_i,
  input  logic                 clear_i,
  output logic [2:0]           fault_mask_o,
  output logic [1:0]           state_o,
  output logic                 alarm_o,
  output logic [15:0]          total_err_o,
  output logic [3*CNT_W-1:0]   cnt_o
);

  localparam int unsigned WIN_W = (WINDOW > 2) ? $clog2(WINDOW) : 1;

  ft_mon_state_e    r_state;
  logic [2:0]       r_mask;
  logic             r_alarm;
  logic [15:0]      r_total;
  logic [WIN_W-1:0] r_win;

  logic             w_clr;
  logic             w_wrap;
  logic [1:0]       w_nerr;
  logic             w_single;
  logic             w_multi;
  logic [2:0]       w_hit;
  logic [CNT_W-1:0] w_cnt [FT_NREP];

  assign w_clr    = rst || clear_i;
  assign w_wrap   = (r_win == WIN_W'(WINDOW - 1));
  assign w_nerr   = popcount3(err_i);
  assign w_single = valid_i && (w_nerr == 2'd1);
  assign w_multi  = valid_i && (w_nerr >= 2'd2);

  for (genvar k = 0; k < FT_NREP; k++) begin : g_rep
    cv32e40p_ft_err_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk      (clk),
      .rst      (w_clr),
      .inc_i    (w_single && err_i[k]),
      .leak_i   (w_wrap),
      .freeze_i (r_mask[k]),
      .cnt_o    (w_cnt[k])
    );
    assign w_hit[k] = (w_cnt[k] >= CNT_W'(THRESH)) && !r_mask[k];
    assign cnt_o[k*CNT_W +: CNT_W] = w_cnt[k];
  end

  // Free-running leak window
  always_ff @(posedge clk) begin
    if (w_clr || w_wrap) r_win <= '0;
    else                 r_win <= r_win + WIN_W'(1);
  end

  // Saturating count of erroneous valid samples
  always_ff @(posedge clk) begin
    if (w_clr) begin
      r_total <= '0;
    end else if (valid_i && (err_i != 3'b000) && (r_total != 16'hFFFF)) begin
      r_total <= r_total + 16'd1;
    end
  end

  // Monitor state machine; FAILED is sticky until clear or reset
  always_ff @(posedge clk) begin
    if (w_clr) begin
      r_state <= FT_OK;
      r_mask  <= '0;
      r_alarm <= 1'b0;
    end else begin
      case (r_state)
        FT_OK: begin
          if (w_multi || (popcount3(w_hit) >= 2'd2)) begin
            r_state <= FT_FAILED;
            r_alarm <= 1'b1;
          end else if (w_hit != 3'b000) begin
            r_state <= FT_DEGRADED;
            r_mask  <= r_mask | w_hit;
          end
        end
        FT_DEGRADED: begin
          if (w_multi || (w_hit != 3'b000)) begin
            r_state <= FT_FAILED;
            r_alarm <= 1'b1;
          end
        end
        default: begin
          r_state <= FT_FAILED;
          r_alarm <= 1'b1;
        end
      endcase
    end
  end

  assign fault_mask_o = r_mask;
  assign state_o      = r_state;
  assign alarm_o      = r_alarm;
  assign total_err_o  = r_total;

endmodule

// File: tb/tb_cv32e40p_mult_ft_monitor.sv
// Directed bench for the multiplier fault-tolerance monitor (THRESH=4, WINDOW=16, CNT_W=8).
module tb_cv32e40p_mult_ft_monitor;

  localparam int unsigned CNT_W = 8;

  logic               clk = 1'b0;
  logic               rst;
  logic               valid_i;
  logic [2:0]         err_i;
  logic               clear_i;
  logic [2:0]         fault_mask_o;
  logic [1:0]         state_o;
  logic               alarm_o;
  logic [15:0]        total_err_o;
  logic [3*CNT_W-1:0] cnt_o;

  int n_total = 0;
  int n_pass  = 0;

  cv32e40p_mult_ft_monitor #(.THRESH(4), .CNT_W(CNT_W), .WINDOW(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .valid_i      (valid_i),
    .err_i        (err_i),
    .clear_i      (clear_i),
    .fault_mask_o (fault_mask_o),
    .state_o      (state_o),
    .alarm_o      (alarm_o),
    .total_err_o  (total_err_o),
    .cnt_o        (cnt_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // One clock edge with the given inputs; outputs settle 1 time unit later.
  task automatic step(input logic v, input logic [2:0] e, input logic c, input logic r);
    valid_i = v; err_i = e; clear_i = c; rst = r;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 3'b000, 1'b0, 1'b0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_cnt"},   32'(cnt_o),        32'h0);
    chk({tag, "_mask"},  32'(fault_mask_o), 32'h0);
    chk({tag, "_state"}, 32'(state_o),      32'h0);
    chk({tag, "_alarm"}, 32'(alarm_o),      32'h0);
    chk({tag, "_total"}, 32'(total_err_o),  32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset
    step(1'b1, 3'b111, 1'b1, 1'b1);
    step(1'b0, 3'b000, 1'b0, 1'b1);
    chk_all_zero("reset");

    // Four single faults on replica 1 -> DEGRADED one edge after the 4th sample
    step(1'b0, 3'b000, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 3'b010, 1'b0, 1'b0);
    chk("deg_cnt1_at4",   32'(cnt_o[15:8]), 32'd4);
    chk("deg_state_lat",  32'(state_o),     32'd0);
    idle(1);
    chk("deg_state",      32'(state_o),      32'd1);
    chk("deg_mask",       32'(fault_mask_o), 32'b010);
    chk("deg_cnt1",       32'(cnt_o[15:8]),  32'd4);
    chk("deg_alarm",      32'(alarm_o),      32'd0);

    // Fault on the isolated replica only bumps the total
    step(1'b1, 3'b010, 1'b0, 1'b0);
    chk("iso_cnt1",       32'(cnt_o[15:8]), 32'd4);
    chk("iso_total",      32'(total_err_o), 32'd5);

    // Second replica reaches threshold while DEGRADED -> FAILED
    for (int i = 0; i < 4; i++) step(1'b1, 3'b001, 1'b0, 1'b0);
    idle(1);
    chk("fail2_state",    32'(state_o),      32'd2);
    chk("fail2_alarm",    32'(alarm_o),      32'd1);
    chk("fail2_mask",     32'(fault_mask_o), 32'b010);
    chk("fail2_total",    32'(total_err_o),  32'd9);
    chk("fail2_cnt0",     32'(cnt_o[7:0]),   32'd4);

    // Clear wins over a same-cycle sample
    step(1'b1, 3'b001, 1'b1, 1'b0);
    chk_all_zero("clear");

    // Uncorrectable sample from OK
    step(1'b1, 3'b101, 1'b0, 1'b0);
    chk("unc_state",      32'(state_o),     32'd2);
    chk("unc_alarm",      32'(alarm_o),     32'd1);
    chk("unc_total",      32'(total_err_o), 32'd1);
    chk("unc_cnt",        32'(cnt_o),       32'd0);
    for (int i = 0; i < 6; i++) step(1'b1, 3'b011, 1'b0, 1'b0);
    chk("unc_total7",     32'(total_err_o), 32'd7);
    chk("unc_sticky",     32'(state_o),     32'd2);

    // Reset from FAILED beats clear and valid
    step(1'b1, 3'b001, 1'b1, 1'b1);
    chk_all_zero("rst_failed");

    // Leak: 3 faults then 48 idle cycles drain replica 0
    for (int i = 0; i < 3; i++) step(1'b1, 3'b001, 1'b0, 1'b0);
    chk("leak_cnt0_3",    32'(cnt_o[7:0]), 32'd3);
    idle(13);
    chk("leak_cnt0_2",    32'(cnt_o[7:0]), 32'd2);
    idle(35);
    chk("leak_cnt0_0",    32'(cnt_o[7:0]), 32'd0);
    chk("leak_state",     32'(state_o),    32'd0);

    // Increment coinciding with the leak leaves the counter unchanged
    step(1'b0, 3'b000, 1'b1, 1'b0);
    step(1'b1, 3'b100, 1'b0, 1'b0);
    step(1'b1, 3'b100, 1'b0, 1'b0);
    chk("wrap_cnt2_pre",  32'(cnt_o[23:16]), 32'd2);
    idle(13);
    step(1'b1, 3'b100, 1'b0, 1'b0);
    chk("wrap_cnt2_same", 32'(cnt_o[23:16]), 32'd2);
    chk("wrap_total",     32'(total_err_o),  32'd3);
    idle(16);
    chk("wrap_cnt2_leak", 32'(cnt_o[23:16]), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
